// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the modulo BCD counter.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;

    function automatic logic [15:0] int_to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [15:0] v, input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < n && v[4*i +: 4] > BCD_MAX_DIGIT)
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple chain: load, increment or decrement when enabled.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             ci,
    input  logic             load,
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] d,
    output logic             co,
    output logic             bo
);

    assign co = ci & inc & (d == BCD_MAX_DIGIT);
    assign bo = ci & dec & (d == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d <= '0;
        end else if (load) begin
            d <= din;
        end else if (ci & inc) begin
            d <= co ? '0 : d + 4'd1;
        end else if (ci & dec) begin
            d <= bo ? BCD_MAX_DIGIT : d - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter with up/down, load and cascadable tc.
// Optional free-running prescaler enabled by defining BCD_CNT_PRESCALER_EN.
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int MOD    = 60,
    parameter int DIV    = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [BCD_W*DIGITS-1:0] din,
    output logic [BCD_W*DIGITS-1:0] q,
    output logic                  tc,
    output logic                  load_err
);

    localparam int W = BCD_W * DIGITS;
    localparam logic [15:0] TERM16 = int_to_bcd(MOD - 1);
    localparam logic [W-1:0] TERM_UP = TERM16[W-1:0];

    if (DIGITS < 1 || DIGITS > 4)
        $error("DIGITS out of range");
    if (MOD < 2)
        $error("MOD too small");

    logic tick;
    logic step;
    logic din_ok;
    logic load_ok;
    logic at_term;
    logic inc;
    logic dec;
    logic dig_load;
    logic [W-1:0] dig_din;
    logic [15:0] din16;
    logic [DIGITS-1:0] ci;
    logic [DIGITS-1:0] nxt;
    logic [DIGITS-1:0] co;
    logic [DIGITS-1:0] bo;
    logic unused_top;

`ifdef BCD_CNT_PRESCALER_EN
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    logic [PW-1:0] pcnt;

    if (DIV < 2)
        $error("DIV too small");

    assign tick = (pcnt == PW'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pcnt <= '0;
        else if (tick)
            pcnt <= '0;
        else
            pcnt <= pcnt + 1'b1;
    end
`else
    localparam int unused_div = DIV;
    assign tick = 1'b1;
`endif

    assign step = en & tick;

    // Valid BCD preserves numeric order, so "< MOD" is "<= MOD-1" in BCD.
    assign din16   = 16'(din);
    assign din_ok  = bcd_valid(din16, DIGITS) && (din <= TERM_UP);
    assign load_ok = load & din_ok;

    assign at_term = up ? (q == TERM_UP) : (q == '0);
    assign tc      = step & ~load & at_term;

    assign inc = step & up & ~load;
    assign dec = step & ~up & ~load;

    // Modulo wrap is a forced load of the opposite end value.
    assign dig_load = load_ok | tc;
    assign dig_din  = load_ok ? din : (up ? '0 : TERM_UP);

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        if (g == 0) begin : g_first
            assign ci[g] = 1'b1;
        end else begin : g_rest
            assign ci[g] = nxt[g-1];
        end

        assign nxt[g] = co[g] | bo[g];

        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .inc   (inc),
            .dec   (dec),
            .ci    (ci[g]),
            .load  (dig_load),
            .din   (dig_din[BCD_W*g +: BCD_W]),
            .d     (q[BCD_W*g +: BCD_W]),
            .co    (co[g]),
            .bo    (bo[g])
        );
    end

    assign unused_top = nxt[DIGITS-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            load_err <= 1'b0;
        else
            load_err <= load & ~din_ok;
    end

endmodule
